hdmi_bringup_seq: RTL and testbench
===================================

# hdmi_bringup_seq

Power-up and recovery sequencer for the KC705 HDMI output path. It watches the clock-generator lock, then releases resets in order: the HDMI core reset and the PCA9548 I2C mux reset. It then starts the ADV7511 I2C init engine, supervises it with a timeout and bounded retries, and enables video only after init succeeds. It sits between `clk_gen_kc705` and `hdmi_top`, and it replaces the ad-hoc counter reset in the synthesis top.

## Interface

Parameters:
- `RST_CYCLES`, 256: cycles spent in RST_HOLD.
- `SETTLE_CYCLES`, 64: cycles spent in SETTLE, after mux release and before the init kick.
- `INIT_TIMEOUT`, 1048576: maximum cycles in INIT_WAIT before a timeout.
- `BACKOFF_CYCLES`, 4096: reset-hold cycles between retries.
- `MAX_RETRIES`, 3: retries after the first attempt (total attempts = MAX_RETRIES+1).
- `HPD_DEBOUNCE`, 1024: consecutive low cycles of the synchronised HPD that count as an unplug.

Ports (clock and reset first):
- `clk_50mhz`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: asynchronous reset, active-high.
- `mmcm_locked`, in, 1: MMCM lock. Asynchronous; the block synchronises it with 2 flops.
- `hdmi_hpd`, in, 1: ADV7511 hot-plug detect. Asynchronous; the block synchronises it with 2 flops.
- `init_done`, in, 1: I2C init engine reports success. Level signal.
- `init_error`, in, 1: I2C init engine reports failure (NACK). Level signal.
- `core_rst_n`, out, 1: active-low reset to `hdmi_top`.
- `i2c_mux_reset_n`, out, 1: active-low reset to the PCA9548 mux.
- `init_start`, out, 1: one-cycle pulse that starts the init engine.
- `video_en`, out, 1: enables pixel output.
- `fault`, out, 1: set when retries are exhausted.
- `retry_cnt`, out, $clog2(MAX_RETRIES+1): number of failed attempts since the last success.
- `seq_state`, out, 3: current state code.

## Operation

States and their codes:
- WAIT_LOCK = 0
- RST_HOLD = 1
- SETTLE = 2
- INIT_KICK = 3
- INIT_WAIT = 4
- VIDEO_ON = 5
- BACKOFF = 6
- FAULT = 7

Output values per state:
- WAIT_LOCK and RST_HOLD: `core_rst_n`=0, `i2c_mux_reset_n`=0.
- BACKOFF: `core_rst_n`=0, `i2c_mux_reset_n`=0.
- SETTLE, INIT_KICK, INIT_WAIT, VIDEO_ON, FAULT: both resets =1.
- `init_start`: 1 only in INIT_KICK.
- `video_en`: 1 only in VIDEO_ON.
- `fault`: 1 only in FAULT.

Transitions:
- WAIT_LOCK → RST_HOLD when `locked_s`=1.
- RST_HOLD → SETTLE after RST_CYCLES cycles.
- SETTLE → INIT_KICK after SETTLE_CYCLES cycles.
- INIT_KICK → INIT_WAIT after one cycle.
- INIT_WAIT exits are resolved by priority: error, then done, then timeout.
  - If `init_error`=1, or the cycle counter reaches INIT_TIMEOUT−1 with neither input high, the attempt has failed:
    - if `retry_cnt`==MAX_RETRIES, go to FAULT (`retry_cnt` is held);
    - otherwise increment `retry_cnt` and go to BACKOFF.
  - Else if `init_done`=1, go to VIDEO_ON and clear `retry_cnt` on the same edge.
  - If `init_error` and `init_done` are high in the same cycle, the attempt counts as a failure.
- BACKOFF → SETTLE after BACKOFF_CYCLES cycles.
- VIDEO_ON → RST_HOLD when `hpd_s` has been 0 for HPD_DEBOUNCE consecutive cycles. `retry_cnt` stays 0.
  - The debounce counter clears on any high sample of `hpd_s` and on entry to VIDEO_ON.
  - HPD is ignored in every other state.
- FAULT is terminal. It exits only on `rst` or on lock loss.
- Lock loss: `locked_s`=0 in any state other than WAIT_LOCK forces WAIT_LOCK on the next edge and clears `retry_cnt`. Lock loss overrides every other transition in the same cycle.

Counters and widths:
- One shared cycle counter, width $clog2 of the largest of RST_CYCLES, SETTLE_CYCLES, INIT_TIMEOUT and BACKOFF_CYCLES.
- It clears to 0 on every state change.
- A state with duration N exits on the edge where the counter equals N−1. Occupancy is exactly N cycles.
- `retry_cnt` saturates at MAX_RETRIES and never wraps.

## Timing

- All outputs are registered and change on the same edge as `seq_state`. There are no combinational paths from inputs to outputs.
- Reset values while `rst`=1 (asynchronous, immediate):
  - `seq_state`=0, `core_rst_n`=0, `i2c_mux_reset_n`=0;
  - `init_start`=0, `video_en`=0, `fault`=0, `retry_cnt`=0;
  - synchroniser flops and counters = 0.
- Lock-in latency: if `mmcm_locked` rises before edge k, then `locked_s`=1 after edge k+1 and RST_HOLD is entered at edge k+2.
- Lock-loss latency: RST/mux reset assert at most 3 edges after `mmcm_locked` falls.
- HPD latency: 2 synchroniser edges plus HPD_DEBOUNCE cycles.
- `init_done` and `init_error` are sampled only in INIT_WAIT. They are ignored during INIT_KICK, including the kick cycle itself.
- If `rst` is asserted mid-sequence, the block restarts at WAIT_LOCK. There is no retained state.

## Test plan

All scenarios use RST_CYCLES=8, SETTLE_CYCLES=4, INIT_TIMEOUT=32, BACKOFF_CYCLES=16, MAX_RETRIES=2, HPD_DEBOUNCE=4.

- **Clean bring-up:** release `rst`, raise lock, raise `init_done` 5 cycles after `init_start`.
  - State sequence 0→1→2→3→4→5.
  - `core_rst_n`/`i2c_mux_reset_n` low for exactly 8 cycles after the lock edge plus 2 synchroniser edges.
  - `init_start` is a single 1-cycle pulse.
  - `video_en`=1 on the edge after `init_done` is sampled; `retry_cnt`=0.
- **Error retry:** assert `init_error` once, then `init_done` on the second attempt.
  - `retry_cnt`=1 and resets low for 16 cycles in BACKOFF.
  - Then `video_en`=1 and `retry_cnt`=0.
- **Timeout to fault:** never assert done or error.
  - Three attempts, each exactly 32 cycles in INIT_WAIT.
  - End state: `seq_state`=7, `fault`=1, `retry_cnt`=2, `video_en`=0, and it stays there.
- **Simultaneous done and error:** assert both in the same INIT_WAIT cycle.
  - Next state is BACKOFF and `retry_cnt` increments.
- **HPD debounce:** in VIDEO_ON, drive HPD low for 3 cycles (no exit), then low for 4+ cycles.
  - Exit to RST_HOLD 2+4 cycles after the fall; `video_en` drops on that same edge.
- **Lock loss mid-init and async reset:** drop lock in INIT_WAIT.
  - Within 3 edges: state 0, both resets low, `retry_cnt`=0.
  - Assert `rst` mid-BACKOFF: all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/hdmi_bringup_seq.sv
// Power-up and recovery sequencer for the KC705 HDMI path: waits for MMCM lock,
// releases core and I2C-mux resets in order, then supervises ADV7511 init with retries.
module hdmi_bringup_seq #(
  parameter int RST_CYCLES     = 256,
  parameter int SETTLE_CYCLES  = 64,
  parameter int INIT_TIMEOUT   = 1048576,
  parameter int BACKOFF_CYCLES = 4096,
  parameter int MAX_RETRIES    = 3,
  parameter int HPD_DEBOUNCE   = 1024
) (
  input  logic                               clk_50mhz,
  input  logic                               rst,
  input  logic                               mmcm_locked,
  input  logic                               hdmi_hpd,
  input  logic                               init_done,
  input  logic                               init_error,
  output logic                               core_rst_n,
  output logic                               i2c_mux_reset_n,
  output logic                               init_start,
  output logic                               video_en,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         seq_state
);

  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B   = (INIT_TIMEOUT > BACKOFF_CYCLES) ? INIT_TIMEOUT : BACKOFF_CYCLES;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // The shared counter also times the HPD debounce window in VIDEO_ON.
  localparam int MAX_ALL = (MAX_C > HPD_DEBOUNCE) ? MAX_C : HPD_DEBOUNCE;
  localparam int CW      = $clog2(MAX_ALL);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_CYCLES - 1);
  localparam logic [CW-1:0] HPD_LAST     = CW'(HPD_DEBOUNCE - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    RST_HOLD  = 3'd1,
    SETTLE    = 3'd2,
    INIT_KICK = 3'd3,
    INIT_WAIT = 3'd4,
    VIDEO_ON  = 3'd5,
    BACKOFF   = 3'd6,
    FAULT     = 3'd7
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [RW-1:0]  retry_nxt;
  logic           lock_meta, locked_s, hpd_meta, hpd_s;

  assign seq_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    if (state != WAIT_LOCK && !locked_s) begin
      state_nxt = WAIT_LOCK;
      retry_nxt = '0;
    end else begin
      case (state)
        WAIT_LOCK: if (locked_s) state_nxt = RST_HOLD;
        RST_HOLD:  if (cnt == RST_LAST) state_nxt = SETTLE; else cnt_nxt = cnt + 1'b1;
        SETTLE:    if (cnt == SETTLE_LAST) state_nxt = INIT_KICK; else cnt_nxt = cnt + 1'b1;
        INIT_KICK: state_nxt = INIT_WAIT;
        INIT_WAIT: begin
          // Error beats done; a timeout only counts when neither is asserted.
          if (init_error || (!init_done && cnt == TIMEOUT_LAST)) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAULT;
            end else begin
              retry_nxt = retry_cnt + 1'b1;
              state_nxt = BACKOFF;
            end
          end else if (init_done) begin
            retry_nxt = '0;
            state_nxt = VIDEO_ON;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        VIDEO_ON: begin
          if (hpd_s)                cnt_nxt   = '0;
          else if (cnt == HPD_LAST) state_nxt = RST_HOLD;
          else                      cnt_nxt   = cnt + 1'b1;
        end
        BACKOFF:   if (cnt == BACKOFF_LAST) state_nxt = SETTLE; else cnt_nxt = cnt + 1'b1;
        FAULT:     state_nxt = FAULT;
        default:   state_nxt = WAIT_LOCK;
      endcase
    end
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they flip on the same edge as seq_state.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      lock_meta       <= 1'b0;
      locked_s        <= 1'b0;
      hpd_meta        <= 1'b0;
      hpd_s           <= 1'b0;
      state           <= WAIT_LOCK;
      cnt             <= '0;
      retry_cnt       <= '0;
      core_rst_n      <= 1'b0;
      i2c_mux_reset_n <= 1'b0;
      init_start      <= 1'b0;
      video_en        <= 1'b0;
      fault           <= 1'b0;
    end else begin
      lock_meta       <= mmcm_locked;
      locked_s        <= lock_meta;
      hpd_meta        <= hdmi_hpd;
      hpd_s           <= hpd_meta;
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry_cnt       <= retry_nxt;
      core_rst_n      <= (state_nxt inside {SETTLE, INIT_KICK, INIT_WAIT, VIDEO_ON, FAULT});
      i2c_mux_reset_n <= (state_nxt inside {SETTLE, INIT_KICK, INIT_WAIT, VIDEO_ON, FAULT});
      init_start      <= (state_nxt == INIT_KICK);
      video_en        <= (state_nxt == VIDEO_ON);
      fault           <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_hdmi_bringup_seq.sv
// Bench for hdmi_bringup_seq: directed bring-up scenarios with literal expectations,
// then randomized stimulus, all compared every cycle against a timestamp-based model.
module tb_hdmi_bringup_seq;

  localparam int RST_C = 8;
  localparam int SET_C = 4;
  localparam int TO_C  = 32;
  localparam int BO_C  = 16;
  localparam int MAXR  = 2;
  localparam int HPD_C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       hdmi_hpd = 1'b1;
  logic       init_done = 1'b0;
  logic       init_error = 1'b0;
  logic       core_rst_n, i2c_mux_reset_n, init_start, video_en, fault;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  int tests_run = 0;
  int tests_failed = 0;

  hdmi_bringup_seq #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .INIT_TIMEOUT(TO_C),
    .BACKOFF_CYCLES(BO_C), .MAX_RETRIES(MAXR), .HPD_DEBOUNCE(HPD_C)
  ) dut (
    .clk_50mhz(clk), .rst(rst), .mmcm_locked(mmcm_locked), .hdmi_hpd(hdmi_hpd),
    .init_done(init_done), .init_error(init_error), .core_rst_n(core_rst_n),
    .i2c_mux_reset_n(i2c_mux_reset_n), .init_start(init_start), .video_en(video_en),
    .fault(fault), .retry_cnt(retry_cnt), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // Reference model: phase code plus the edge index at which it was entered.
  int   m_ph = 0, m_t = 0, m_enter = 0, m_last_high = 0, m_retries = 0;
  logic m_lk1 = 1'b0, m_lk2 = 1'b0, m_hp1 = 1'b0, m_hp2 = 1'b0;
  logic m_lock_seen, m_hpd_seen, m_fail;

  task automatic enter_phase(input int p);
    m_ph    = p;
    m_enter = m_t;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ph = 0; m_t = 0; m_enter = 0; m_last_high = 0; m_retries = 0;
      m_lk1 = 1'b0; m_lk2 = 1'b0; m_hp1 = 1'b0; m_hp2 = 1'b0;
    end else begin
      m_lock_seen = m_lk2;
      m_hpd_seen  = m_hp2;
      m_lk2 = m_lk1; m_lk1 = mmcm_locked;
      m_hp2 = m_hp1; m_hp1 = hdmi_hpd;
      m_t++;
      if (m_hpd_seen) m_last_high = m_t;
      if (m_ph != 0 && !m_lock_seen) begin
        m_retries = 0;
        enter_phase(0);
      end else begin
        case (m_ph)
          0: if (m_lock_seen) enter_phase(1);
          1: if (m_t - m_enter == RST_C) enter_phase(2);
          2: if (m_t - m_enter == SET_C) enter_phase(3);
          3: enter_phase(4);
          4: begin
            m_fail = init_error || (!init_done && (m_t - m_enter == TO_C));
            if (m_fail) begin
              if (m_retries == MAXR) enter_phase(7);
              else begin m_retries++; enter_phase(6); end
            end else if (init_done) begin
              m_retries = 0;
              enter_phase(5);
            end
          end
          5: if (m_t - ((m_enter > m_last_high) ? m_enter : m_last_high) >= HPD_C) enter_phase(1);
          6: if (m_t - m_enter == BO_C) enter_phase(2);
          default: ;
        endcase
      end
    end
  end

  function automatic logic [9:0] model_vec();
    logic up;
    up = (m_ph == 2 || m_ph == 3 || m_ph == 4 || m_ph == 5 || m_ph == 7);
    return {3'(m_ph), up, up, (m_ph == 3), (m_ph == 5), (m_ph == 7), 2'(m_retries)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic lk, input logic hp, input logic dn, input logic er);
    mmcm_locked = lk;
    hdmi_hpd    = hp;
    init_done   = dn;
    init_error  = er;
  endtask

  task automatic stepN(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget);
    int n;
    n = 0;
    while (seq_state != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("reach_state_%0d", code), 32'(seq_state), 32'(code));
  endtask

  // Every cycle: all outputs packed {state, core, mux, start, video, fault, retry}.
  initial forever begin
    @(negedge clk);
    checkOutput($sformatf("cycle_t%0t", $time),
                32'({seq_state, core_rst_n, i2c_mux_reset_n, init_start, video_en, fault, retry_cnt}),
                32'(model_vec()));
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  logic r_lk, r_hp;

  initial begin
    #1 rst = 1'b1;
    stepN(3);
    checkOutput("reset_vector",
                32'({seq_state, core_rst_n, i2c_mux_reset_n, init_start, video_en, fault, retry_cnt}), 32'd0);
    rst = 1'b0;
    stepN(3);
    checkOutput("no_lock_waits", 32'(seq_state), 32'd0);

    // Clean bring-up
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    stepN(2);
    checkOutput("lock_sync_still_0", 32'(seq_state), 32'd0);
    stepN(1);
    checkOutput("rst_hold_entry", 32'(seq_state), 32'd1);
    checkOutput("core_rst_low", 32'(core_rst_n), 32'd0);
    stepN(7);
    checkOutput("rst_hold_last", 32'({seq_state, core_rst_n, i2c_mux_reset_n}), 32'b001_0_0);
    stepN(1);
    checkOutput("settle_release", 32'({seq_state, core_rst_n, i2c_mux_reset_n}), 32'b010_1_1);
    stepN(3);
    checkOutput("settle_last", 32'(seq_state), 32'd2);
    stepN(1);
    checkOutput("kick_pulse", 32'({seq_state, init_start}), 32'b011_1);
    stepN(1);
    checkOutput("kick_single", 32'({seq_state, init_start}), 32'b100_0);
    stepN(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("video_on", 32'({seq_state, video_en, retry_cnt}), 32'b101_1_00);

    // HPD glitch of 3 cycles must not unplug; 4+ low cycles must
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepN(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    stepN(8);
    checkOutput("hpd_glitch_ignored", 32'({seq_state, video_en}), 32'b101_1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepN(5);
    checkOutput("hpd_debounce_hold", 32'({seq_state, video_en}), 32'b101_1);
    stepN(1);
    checkOutput("hpd_unplug_exit", 32'({seq_state, video_en}), 32'b001_0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // Error then success
    wait_state(3'd4, 100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("error_backoff", 32'({seq_state, core_rst_n, i2c_mux_reset_n, retry_cnt}), 32'b110_0_0_01);
    stepN(15);
    checkOutput("backoff_last", 32'(seq_state), 32'd6);
    stepN(1);
    checkOutput("backoff_to_settle", 32'(seq_state), 32'd2);
    wait_state(3'd4, 50);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("retry_success", 32'({seq_state, video_en, retry_cnt}), 32'b101_1_00);

    // Done and error together count as a failure
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wait_state(3'd1, 50);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_state(3'd4, 100);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both_is_failure", 32'({seq_state, retry_cnt}), 32'b110_01);
    wait_state(3'd4, 100);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both_then_success", 32'({seq_state, retry_cnt}), 32'b101_00);

    // Lock loss in INIT_WAIT with a pending retry count
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wait_state(3'd1, 50);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_state(3'd4, 100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_state(3'd4, 100);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    stepN(3);
    checkOutput("lock_loss", 32'({seq_state, core_rst_n, i2c_mux_reset_n, retry_cnt}), 32'b000_0_0_00);

    // Timeouts exhaust retries
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) begin
      wait_state(3'd4, 100);
      stepN(31);
      checkOutput($sformatf("timeout_wait_%0d", a), 32'(seq_state), 32'd4);
      stepN(1);
      if (a < 2) checkOutput($sformatf("timeout_backoff_%0d", a), 32'({seq_state, retry_cnt}), 32'({3'b110, 2'(a + 1)}));
    end
    checkOutput("fault_entry", 32'({seq_state, fault, video_en, retry_cnt, core_rst_n}), 32'b111_1_0_10_1);
    stepN(40);
    checkOutput("fault_sticky", 32'({seq_state, fault, retry_cnt}), 32'b111_1_10);

    // Asynchronous reset in the middle of BACKOFF
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    stepN(4);
    checkOutput("fault_lock_loss", 32'({seq_state, fault}), 32'b000_0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_state(3'd4, 100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    stepN(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_backoff", 32'(seq_state), 32'd6);
    stepN(5);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset",
                   32'({seq_state, core_rst_n, i2c_mux_reset_n, init_start, video_en, fault, retry_cnt}), 32'd0);
    stepN(2);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_lk = mmcm_locked;
      r_hp = hdmi_hpd;
      if (r_lk) r_lk = ($urandom_range(999) >= 3);
      else      r_lk = ($urandom_range(9) == 0);
      if (r_hp) r_hp = ($urandom_range(99) >= 1);
      else      r_hp = ($urandom_range(9) < 3);
      applyStimulus(r_lk, r_hp, ($urandom_range(99) < 3), ($urandom_range(99) < 2));
      rst = ($urandom_range(1999) == 0);
      stepN(1);
    end
    rst = 1'b0;
    stepN(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
